// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared pipeline widths and load-mode encodings
package mips_pipe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_W  = 5;
  localparam int DEF_WB_W   = 2;

  typedef logic [2:0] ld_mode_t;

  localparam ld_mode_t LD_WORD   = 3'd0;
  localparam ld_mode_t LD_BYTE_S = 3'd1;
  localparam ld_mode_t LD_BYTE_U = 3'd2;
  localparam ld_mode_t LD_HALF_S = 3'd3;
  localparam ld_mode_t LD_HALF_U = 3'd4;

endpackage

// File: rtl/mem_wb_skid_stage_if.sv
// rtl/mem_wb_skid_stage_if.sv - MEM-side input and WB-side output bundle of the skid stage
interface mem_wb_skid_stage_if import mips_pipe_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W,
  parameter int WB_W   = DEF_WB_W
);
  logic              in_valid;
  logic              in_ready;
  logic [WB_W-1:0]   EX_WB;
  logic [DATA_W-1:0] EX_ALUresult;
  logic [REG_W-1:0]  EX_RegisterRd;
  ld_mode_t          ld_mode;
  logic [DATA_W-1:0] read_MemoryData;
  logic              stall;
  logic              flush;
  logic              out_valid;
  logic [WB_W-1:0]   WB;
  logic [DATA_W-1:0] MemoryData;
  logic [DATA_W-1:0] ALUresult;
  logic [REG_W-1:0]  RegisterRd;
  logic              misalign;

  // Pipeline-control side: drives the MEM payload and WB back-pressure
  modport master (
    output in_valid, EX_WB, EX_ALUresult, EX_RegisterRd, ld_mode, read_MemoryData, stall, flush,
    input  in_ready, out_valid, WB, MemoryData, ALUresult, RegisterRd, misalign
  );

  // The stage itself
  modport slave (
    input  in_valid, EX_WB, EX_ALUresult, EX_RegisterRd, ld_mode, read_MemoryData, stall, flush,
    output in_ready, out_valid, WB, MemoryData, ALUresult, RegisterRd, misalign
  );
endinterface

// File: rtl/load_align.sv
// rtl/load_align.sv - combinational load-data extraction and misalign detection
module load_align import mips_pipe_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] raw,
  input  logic [1:0]        addr_lo,
  input  ld_mode_t          ld_mode,
  output logic [DATA_W-1:0] data,
  output logic              misalign
);
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Pick the addressed lane, then extend it; misaligned accesses pass the raw word through
  always_comb begin
    byte_lane = raw[7:0];
    case (addr_lo)
      2'd1:    byte_lane = raw[15:8];
      2'd2:    byte_lane = raw[23:16];
      2'd3:    byte_lane = raw[31:24];
      default: byte_lane = raw[7:0];
    endcase
    half_lane = addr_lo[1] ? raw[31:16] : raw[15:0];
    data      = raw;
    misalign  = 1'b0;
    case (ld_mode)
      LD_BYTE_S: data = {{(DATA_W-8){byte_lane[7]}}, byte_lane};
      LD_BYTE_U: data = {{(DATA_W-8){1'b0}}, byte_lane};
      LD_HALF_S: begin
        if (addr_lo[0]) misalign = 1'b1;
        else            data = {{(DATA_W-16){half_lane[15]}}, half_lane};
      end
      LD_HALF_U: begin
        if (addr_lo[0]) misalign = 1'b1;
        else            data = {{(DATA_W-16){1'b0}}, half_lane};
      end
      default:   misalign = (addr_lo != 2'b00);
    endcase
  end
endmodule

// File: rtl/mem_wb_skid_stage.sv
// rtl/mem_wb_skid_stage.sv - MEM/WB pipeline register with one-entry skid buffer
module mem_wb_skid_stage import mips_pipe_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W,
  parameter int WB_W   = DEF_WB_W
) (
  input logic                clk,
  input logic                rst,
  mem_wb_skid_stage_if.slave bus
);
  typedef struct packed {
    logic [WB_W-1:0]   wb;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] alu;
    logic [REG_W-1:0]  rd;
    logic              mis;
  } entry_t;

  entry_t            main_q, skid_q, in_entry;
  logic              main_valid, skid_valid, ready_q;
  logic [DATA_W-1:0] ext_data;
  logic              ext_mis;
  logic              accept, main_free;

  load_align #(.DATA_W(DATA_W)) u_align (
    .raw      (bus.read_MemoryData),
    .addr_lo  (bus.EX_ALUresult[1:0]),
    .ld_mode  (bus.ld_mode),
    .data     (ext_data),
    .misalign (ext_mis)
  );

  assign in_entry  = '{wb: bus.EX_WB, data: ext_data, alu: bus.EX_ALUresult,
                       rd: bus.EX_RegisterRd, mis: ext_mis};
  assign accept    = bus.in_valid && ready_q;
  // Main can take a new entry when it is empty or WB consumes it this cycle
  assign main_free = !main_valid || !bus.stall;

  // Entry movement: skid drains into main before anything new is taken from upstream
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (bus.flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
      main_q.wb  <= '0;
      skid_q.wb  <= '0;
    end else if (skid_valid) begin
      if (main_free) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
        skid_q.wb  <= '0;
        ready_q    <= 1'b1;
      end
    end else if (accept) begin
      if (main_free) begin
        main_q     <= in_entry;
        main_valid <= 1'b1;
      end else begin
        skid_q     <= in_entry;
        skid_valid <= 1'b1;
        ready_q    <= 1'b0;
      end
    end else if (main_valid && !bus.stall) begin
      main_valid <= 1'b0;
      main_q.wb  <= '0;
    end
  end

  assign bus.in_ready   = ready_q;
  assign bus.out_valid  = main_valid;
  assign bus.WB         = main_q.wb;
  assign bus.MemoryData = main_q.data;
  assign bus.ALUresult  = main_q.alu;
  assign bus.RegisterRd = main_q.rd;
  assign bus.misalign   = main_q.mis;
endmodule

// File: doc/mem_wb_skid_stage.md
MEM_WB_SKID_STAGE -- requirements
Module: mem_wb_skid_stage

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, datapath and memory-data width (multiple of 16).
REQ-002 SHALL provide parameter REG_W, default 5, destination-register index width.
REQ-003 SHALL provide parameter WB_W, default 2, write-back control field width.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL provide port clk  input  1  clock; all state updates on rising edge.
REQ-006 SHALL provide port rst  input  1  synchronous active-high reset.
REQ-007 SHALL provide port in_valid  input  1  MEM stage presents an instruction.
REQ-008 SHALL provide port in_ready  output  1  stage can accept; registered.
REQ-009 SHALL provide port EX_WB  input  WB_W  write-back control of incoming instruction.
REQ-010 SHALL provide port EX_ALUresult  input  DATA_W  ALU result / memory address.
REQ-011 SHALL provide port EX_RegisterRd  input  REG_W  destination register.
REQ-012 SHALL provide port ld_mode  input  3  load extraction mode (package encoding).
REQ-013 SHALL provide port read_MemoryData  input  DATA_W  raw D-cache read word, valid with in_valid.
REQ-014 SHALL provide port stall  input  1  WB side cannot consume this cycle.
REQ-015 SHALL provide port flush  input  1  discard all held instructions.
REQ-016 SHALL provide ports out_valid 1, WB WB_W, MemoryData DATA_W, ALUresult DATA_W, RegisterRd REG_W, misalign 1, all outputs, all registered.

Function
REQ-017 SHALL hold two entries: main (drives outputs) and skid; each with its own valid bit.
REQ-018 SHALL accept when in_valid && in_ready; accepted data appears on outputs next cycle if main is empty or consumed (latency 1).
REQ-019 SHALL treat main as consumed when out_valid && !stall.
REQ-020 SHALL write an accepted entry into skid when main is valid and stall is high; in_ready SHALL be !skid_valid registered.
REQ-021 SHALL, when stall drops with skid valid, move skid to main that cycle and accept no new entry into main from upstream except into skid.
REQ-022 SHALL preserve strict program order; no entry dropped or duplicated under any stall pattern.
REQ-023 SHALL force WB output to 0 whenever out_valid is 0.
REQ-024 SHALL extract load data before capture: mode 0 word, 1 byte signed, 2 byte unsigned, 3 half signed, 4 half unsigned; others treated as word.
REQ-025 SHALL select byte lane by EX_ALUresult[1:0] and half lane by EX_ALUresult[1] (little-endian, lane 0 = bits 7:0).
REQ-026 SHALL set misalign for half with address bit0=1 or word with address bits[1:0]!=0; extracted data then equals raw word.
REQ-027 SHALL, on flush, clear both valid bits and WB next cycle; flush wins over simultaneous accept, move and stall.
REQ-028 SHALL drive in_ready=1 the cycle after flush.
REQ-029 SHALL keep data/address fields unchanged (not cleared) when an entry is invalidated; only valid and WB are cleared.

Reset
REQ-030 SHALL on rst clear out_valid, skid valid, WB, MemoryData, ALUresult, RegisterRd, misalign to 0 and set in_ready to 1 next cycle.
REQ-031 SHALL give rst priority over flush, stall and in_valid; reset mid-transfer discards both entries.

Structure
REQ-032 SHALL place ld_mode encodings and default widths in shared package mips_pipe_pkg.
REQ-033 SHALL implement extraction and misalign detection as combinational sub-module load_align.

Verification
REQ-034 SHALL test: raw 0x8899AABB, ld_mode 1, addr 0x...01 -> MemoryData 0xFFFFFFAA, misalign 0, one cycle later.
REQ-035 SHALL test: ld_mode 4, addr 0x...02, raw 0x8899AABB -> 0x00008899; addr 0x...03 -> misalign 1, data 0x8899AABB.
REQ-036 SHALL test: back-to-back A,B,C with stall high 3 cycles from cycle of B -> outputs A held, B in skid, in_ready 0, C held upstream; after release order A,B,C.
REQ-037 SHALL test: flush same cycle as accept with skid valid -> out_valid 0, WB 0 next cycle, in_ready 1, neither entry later emitted.
REQ-038 SHALL test: rst asserted with both entries valid and stall high -> all outputs 0, in_ready 1 next cycle.
REQ-039 SHALL test: random in_valid/stall 10k cycles with DATA_W=64 -> scoreboard exact in-order match, no loss.
